// File: rtl/counter.sv
// Ripple up-counter: WIDTH toggle stages, stage 0 clocked by falling clock, stage i by falling Q[i-1].
// Q ripples to its settled value within the falling-edge step; no flow control, counts unconditionally.

module counter_dff (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic d_i,
    output logic q_o
);
    logic q_q;

    always_ff @(negedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;
endmodule

module counter_tff (
    input  logic clk_i,
    input  logic clr_n_i,
    output logic q_o
);
    logic q_d;

    // Feeding back the inverted stored bit makes every active edge a toggle.
    assign q_d = ~q_o;

    counter_dff u_dff (
        .clk_i   (clk_i),
        .clr_n_i (clr_n_i),
        .d_i     (q_d),
        .q_o     (q_o)
    );
endmodule

module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] stage_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            counter_tff u_tff (
                .clk_i   (clock),
                .clr_n_i (clear),
                .q_o     (stage_q[0])
            );
        end else begin : g_rest
            // A stage's falling output is the carry into the next stage.
            counter_tff u_tff (
                .clk_i   (stage_q[i-1]),
                .clr_n_i (clear),
                .q_o     (stage_q[i])
            );
        end
    end

    assign Q = stage_q;
endmodule

// File: tb/tb_counter.sv
// Bench for the ripple counter: directed timeline plus randomized asynchronous clears,
// checked every rising edge against an arithmetic count model.

module tb_counter;
    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clock;
    logic         clear;
    logic [W-1:0] Q;

    int n_pass  = 0;
    int n_total = 0;

    int           model_cnt = 0;
    bit           started   = 1'b0;
    int           tog [W];
    logic [W-1:0] q_prev;

    counter #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .Q     (Q)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Reference: the count is the number of falling edges seen with clear high, mod 2^W.
    always @(negedge clear) model_cnt = 0;
    always @(negedge clock) begin
        if (clear === 1'b1) begin
            model_cnt = (model_cnt + 1) % MOD;
        end
    end

    // Q must be settled and equal to the model by every rising edge, and not move across it.
    always @(posedge clock) begin
        logic [W-1:0] pre;
        if (started) begin
            pre = Q;
            check("model", int'(Q), model_cnt);
            #1;
            check("rise_stable", int'(Q), int'(pre));
        end
    end

    always @(Q) begin
        for (int i = 0; i < W; i++) begin
            if (Q[i] != q_prev[i]) tog[i]++;
        end
        q_prev = Q;
    end

    task automatic random_offset(output int off);
        off = $urandom_range(2, 16);
        if (off >= 9) off += 3;
    endtask

    initial begin
        int off;
        int n;
        clear = 1'b0;
        for (int i = 0; i < W; i++) tog[i] = 0;
        q_prev = '0;

        #1;
        started = 1'b1;
        check("reset_t1", int'(Q), 0);
        #24;
        check("reset_hold_25", int'(Q), 0);
        #9;
        clear = 1'b1;                          // t=34
        #11;                                   // t=45
        for (int k = 1; k <= 10; k++) begin
            check("count_up", int'(Q), k);
            if (k < 10) #20;
        end
        #9;
        clear = 1'b0;                          // t=234, clock high
        #1;
        check("async_clear", int'(Q), 0);
        #10;
        check("held_245", int'(Q), 0);
        #20;
        check("held_265", int'(Q), 0);
        #19;
        clear = 1'b1;                          // t=284
        #1;
        check("held_285", int'(Q), 0);
        #20;                                   // t=305
        for (int k = 1; k <= 5; k++) begin
            check("resume", int'(Q), k);
            if (k < 5) #20;
        end
        #9;
        clear = 1'b0;                          // t=394
        #2;
        clear = 1'b1;                          // t=396
        for (int i = 0; i < W; i++) tog[i] = 0;
        #289;                                  // t=685, 15 edges since release
        check("wrap_15", int'(Q), 15);
        #20;
        check("wrap_0", int'(Q), 0);
        #20;
        check("wrap_1", int'(Q), 1);
        #300;                                  // t=1025, 32 edges since release
        check("after_32", int'(Q), 0);
        check("tog_bit0", tog[0], 32);
        for (int i = 1; i < W; i++) begin
            check("tog_ratio", tog[i] * 2, tog[i-1]);
        end

        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 40);
            repeat (n) @(negedge clock);
            random_offset(off);
            #(off);
            clear = 1'b0;
            #1;
            check("rand_async_clear", int'(Q), 0);
            n = $urandom_range(1, 3);
            repeat (n) @(negedge clock);
            random_offset(off);
            #(off);
            clear = 1'b1;
        end
        repeat (20) @(negedge clock);
        #5;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: WIDTH, default 4, number of counter bits (ripple stages); must be at least 1.
REQ-002 Port: clock  input  1  count clock; every falling edge advances the count.
REQ-003 Port: clear  input  1  reset, asynchronous, active-low; 0 clears the counter.
REQ-004 Port: Q  output  WIDTH  current count value, unsigned, registered.
REQ-005 The block SHALL have one clock (clock), and its reset (clear) SHALL be asynchronous and active-low.

Function
REQ-006 The counter SHALL be built as a ripple counter of WIDTH toggle stages.
- Each toggle stage SHALL be a T flip-flop.
- Each T flip-flop SHALL be built from a D flip-flop with asynchronous active-low clear.
- The D input SHALL be the inverted stored bit.
REQ-007 Stage 0 SHALL toggle Q[0] on every falling edge of clock while clear=1.
REQ-008 Stage i (i>0) SHALL toggle Q[i] on every falling edge of Q[i-1] while clear=1.
REQ-009 Net effect: Q SHALL increment by exactly 1 (mod 2^WIDTH) per falling clock edge.
REQ-010 Rising clock edges SHALL have no effect on Q.
REQ-011 Q SHALL wrap from 2^WIDTH-1 (15 for WIDTH=4) to 0 on the next falling edge, with no flag and no stall.
REQ-012 Ripple settling:
- Q SHALL be stable and correct before the next rising clock edge.
- Intermediate ripple values inside one falling-edge time step are permitted.
- Benches SHALL sample Q only after settling.
REQ-013 The design SHALL have no enable, no load and no direction control; counting is unconditional while clear=1.
REQ-014 The design SHALL have no combinational path from clock to Q other than through the flip-flops.

Reset
REQ-015 clear=0 SHALL force every stage, and so Q, to 0 immediately, without waiting for any clock edge.
REQ-016 While clear=0, Q SHALL hold 0 regardless of clock activity.
REQ-017 A falling edge of the reset-released Q[i-1] SHALL NOT toggle stage i while clear=0.
REQ-018 Reset release:
- After clear rises, the first increment (0->1) SHALL occur on the first falling clock edge strictly after the release.
- A falling edge coincident with the release SHALL NOT count; benches SHALL avoid exact coincidence.
REQ-019 Reset asserted mid-count SHALL abort the count and return Q to 0 within the same time step.
- The count SHALL resume from 0 after release.
REQ-020 The power-up value before the first clear assertion is undefined; benches SHALL assert clear at time 0.

Verification
Bench clock: clock=0 at t=0, toggling every 10 ns, so falling edges fall at 20, 40, 60 ... ns.
REQ-021 Reset hold: clear=0 from t=0 to t=34, clock running -> Q=0 throughout, including after the falling edge at 20 ns.
REQ-022 Count-up: release clear at t=34 -> Q=1 after the edge at 40 ns, Q=2 after 60 ns, ..., Q=10 after 220 ns.
REQ-023 Asynchronous mid-count reset: from the REQ-022 state, drive clear=0 at t=234 -> Q=0 at 234 ns with no clock edge.
- Q stays 0 through the falling edges at 240, 260 and 280 ns.
REQ-024 Resume: release clear at t=284 -> Q=1 after 300 ns, ..., Q=5 after 380 ns.
REQ-025 Wrap-around: from reset release, apply 15 falling edges -> Q=15; the 16th falling edge -> Q=0; the 17th -> Q=1.
REQ-026 Edge sensitivity: across a full run, Q SHALL never change on a rising clock edge.
- Each stage Q[i] SHALL toggle exactly once per two toggles of Q[i-1], checked over 32 counts.
